eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Transmit-side Ethernet framer: preamble/SFD, zero padding to the minimum size,
// CRC-32 FCS append, abort marking on underrun/oversize, and inter-frame gap.
module eth_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int IFG_BYTES       = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int               CNT_W    = $clog2(IFG_BYTES + 8);
  localparam logic [10:0]      MIN_CNT  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]      MAX_CNT  = 11'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [31:0]      CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_crc, w_crc_nxt;
  logic [10:0]      r_byte_cnt, w_byte_cnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_tx_data, w_tx_data;
  logic             r_tx_en, w_tx_en;
  logic             r_tx_er, w_tx_er;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic [31:0]      w_fcs;
  logic [7:0]       w_fcs_byte;
  logic [10:0]      w_byte_cnt_inc;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign w_fcs          = ~r_crc;
  assign w_fcs_byte     = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
  assign w_byte_cnt_inc = r_byte_cnt + 11'd1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    w_state_nxt    = r_state;
    w_crc_nxt      = r_crc;
    w_byte_cnt_nxt = r_byte_cnt;
    w_cnt_nxt      = r_cnt;
    w_tx_data      = 8'h00;
    w_tx_en        = 1'b0;
    w_tx_er        = 1'b0;
    w_done         = 1'b0;
    w_err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (s_valid) begin
          w_state_nxt    = S_PRE;
          w_tx_data      = 8'h55;
          w_tx_en        = 1'b1;
          w_crc_nxt      = CRC_INIT;
          w_byte_cnt_nxt = '0;
          w_cnt_nxt      = '0;
        end
      end
      S_PRE: begin
        w_tx_data = 8'h55;
        w_tx_en   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == PRE_LAST) w_state_nxt = S_SFD;
      end
      S_SFD: begin
        w_tx_data   = 8'hD5;
        w_tx_en     = 1'b1;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        // Abort on starvation or on a byte past the maximum; a last byte taken
        // on the abort edge leaves nothing to drain.
        if (r_byte_cnt == MAX_CNT || !s_valid) begin
          w_tx_en     = 1'b1;
          w_tx_er     = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = (s_valid && s_last) ? S_IFG : S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_tx_data      = s_data;
          w_tx_en        = 1'b1;
          w_crc_nxt      = crc32_byte(r_crc, s_data);
          w_byte_cnt_nxt = w_byte_cnt_inc;
          if (s_last) begin
            w_state_nxt = (w_byte_cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_PAD: begin
        w_tx_en        = 1'b1;
        w_crc_nxt      = crc32_byte(r_crc, 8'h00);
        w_byte_cnt_nxt = w_byte_cnt_inc;
        if (w_byte_cnt_inc == MIN_CNT) begin
          w_state_nxt = S_FCS;
          w_cnt_nxt   = '0;
        end
      end
      S_FCS: begin
        w_tx_data = w_fcs_byte;
        w_tx_en   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt[1:0] == 2'd3) begin
          w_done      = 1'b1;
          w_state_nxt = S_IFG;
          w_cnt_nxt   = '0;
        end
      end
      S_IFG: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == IFG_LAST) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (s_valid && s_last) begin
          w_state_nxt = S_IFG;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc      <= CRC_INIT;
      r_byte_cnt <= '0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_crc      <= w_crc_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data;
      r_tx_en    <= w_tx_en;
      r_tx_er    <= w_tx_er;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign s_ready    = rst_n && (r_state == S_DATA || r_state == S_DRAIN);
  assign busy       = (r_state != S_IDLE);
  assign tx_data    = r_tx_data;
  assign tx_en      = r_tx_en;
  assign tx_er      = r_tx_er;
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed testbench for eth_tx_framer: default instance plus a MIN_FRAME_BYTES=9
// instance for the standard "123456789" CRC vector.
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       sel;

  always #5 clk = ~clk;

  logic [7:0] t0_data, t9_data;
  logic t0_ready, t0_en, t0_er, t0_busy, t0_done, t0_err;
  logic t9_ready, t9_en, t9_er, t9_busy, t9_done, t9_err;

  eth_tx_framer u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && !sel), .s_last(s_last),
    .s_ready(t0_ready), .tx_data(t0_data), .tx_en(t0_en), .tx_er(t0_er),
    .busy(t0_busy), .frame_done(t0_done), .frame_err(t0_err)
  );

  eth_tx_framer #(.MIN_FRAME_BYTES(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid && sel), .s_last(s_last),
    .s_ready(t9_ready), .tx_data(t9_data), .tx_en(t9_en), .tx_er(t9_er),
    .busy(t9_busy), .frame_done(t9_done), .frame_err(t9_err)
  );

  logic [7:0] m_tx_data;
  logic m_ready, m_tx_en, m_tx_er, m_busy, m_done, m_err;
  assign m_tx_data = sel ? t9_data  : t0_data;
  assign m_ready   = sel ? t9_ready : t0_ready;
  assign m_tx_en   = sel ? t9_en    : t0_en;
  assign m_tx_er   = sel ? t9_er    : t0_er;
  assign m_busy    = sel ? t9_busy  : t0_busy;
  assign m_done    = sel ? t9_done  : t0_done;
  assign m_err     = sel ? t9_err   : t0_err;

  typedef struct packed {
    logic [7:0] d;
    logic en, er, done, err, busy, rdy;
  } smp_t;

  smp_t       log_q[$];
  logic [7:0] pl [2][2048];
  int         pass_cnt = 0;
  int         total    = 0;

  always @(negedge clk) log_q.push_back({m_tx_data, m_tx_en, m_tx_er, m_done, m_err, m_busy, m_ready});

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  function automatic int find_en(input int from);
    for (int k = from; k < log_q.size(); k++) if (log_q[k].en === 1'b1) return k;
    return -1;
  endfunction

  function automatic int run_end(input int s);
    int k = s;
    while (k + 1 < log_q.size() && log_q[k+1].en === 1'b1) k++;
    return k;
  endfunction

  task automatic clear_log();
    @(posedge clk);
    log_q.delete();
  endtask

  task automatic drive(input int slot, input int n, input bit with_last, input int gap_at);
    int  i = 0;
    int  guard = 0;
    bit  gap_done = 1'b0;
    logic rdy;
    @(negedge clk);
    while (i < n && guard < 4000) begin
      rdy = m_ready;
      if (rdy && i == gap_at && !gap_done) begin
        s_valid  = 1'b0;
        s_last   = 1'b0;
        gap_done = 1'b1;
      end else begin
        s_valid = 1'b1;
        s_data  = pl[slot][i];
        s_last  = with_last && (i == n - 1);
        if (rdy) i++;
      end
      guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    total++;
    if (i != n) $display("FAIL drive_handshake: accepted %0d bytes, required %0d", i, n);
    else pass_cnt++;
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    @(negedge clk);
    while (m_busy !== 1'b0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (m_busy !== 1'b0) $display("FAIL %s idle_timeout: busy=%b, required 0", nm, m_busy);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int slot, input int n, input int minb,
                             input int s, output int e, output logic [31:0] fcs_obs);
    int          body_len, bad, bad_i, dn_cnt, dn_idx, er_cnt;
    logic [63:0] pre;
    logic [31:0] crc, res;
    logic [7:0]  exp_b, bad_o, bad_e;
    body_len = (n < minb) ? minb : n;
    fcs_obs  = '0;
    e        = (s < 0) ? 0 : run_end(s);
    total++;
    if (s < 0 || e - s + 1 != 8 + body_len + 4) begin
      $display("FAIL %s tx_en_len: start %0d len %0d, required len %0d", nm, s, e - s + 1, 8 + body_len + 4);
      return;
    end
    pass_cnt++;

    pre = '0;
    for (int i = 0; i < 8; i++) pre = {pre[55:0], log_q[s+i].d};
    total++;
    if (pre !== 64'h5555_5555_5555_55D5) $display("FAIL %s preamble: got %h, required 55555555555555d5", nm, pre);
    else pass_cnt++;

    crc = 32'hFFFF_FFFF;
    bad = 0; bad_i = 0; bad_o = 0; bad_e = 0;
    for (int i = 0; i < body_len; i++) begin
      exp_b = (i < n) ? pl[slot][i] : 8'h00;
      if (log_q[s+8+i].d !== exp_b) begin
        if (bad == 0) begin bad_i = i; bad_o = log_q[s+8+i].d; bad_e = exp_b; end
        bad++;
      end
      crc = crc_upd(crc, exp_b);
    end
    total++;
    if (bad != 0) $display("FAIL %s body: %0d bad bytes, first at %0d got %h required %h", nm, bad, bad_i, bad_o, bad_e);
    else pass_cnt++;

    fcs_obs = {log_q[e].d, log_q[e-1].d, log_q[e-2].d, log_q[e-3].d};
    total++;
    if (fcs_obs !== ~crc) $display("FAIL %s fcs: got %h, required %h", nm, fcs_obs, ~crc);
    else pass_cnt++;

    res = 32'hFFFF_FFFF;
    for (int k = s + 8; k <= e; k++) res = crc_upd(res, log_q[k].d);
    total++;
    if (res !== 32'hDEBB_20E3) $display("FAIL %s residue: got %h, required debb20e3", nm, res);
    else pass_cnt++;

    dn_cnt = 0; dn_idx = -1; er_cnt = 0;
    for (int k = s; k <= e + 1 && k < log_q.size(); k++) begin
      if (log_q[k].done === 1'b1) begin dn_cnt++; dn_idx = k; end
      if (log_q[k].er === 1'b1 || log_q[k].err === 1'b1) er_cnt++;
    end
    total++;
    if (dn_cnt != 1 || dn_idx != e) $display("FAIL %s frame_done: %0d pulses at %0d, required 1 at %0d", nm, dn_cnt, dn_idx, e);
    else pass_cnt++;
    total++;
    if (er_cnt != 0) $display("FAIL %s error_flags: %0d cycles with tx_er/frame_err, required 0", nm, er_cnt);
    else pass_cnt++;
  endtask

  task automatic check_ifg(input string nm, input int e);
    int k = e + 1;
    int en_cnt = 0;
    while (k < log_q.size() && log_q[k].busy === 1'b1) k++;
    total++;
    if (k != e + 12) $display("FAIL %s ifg_busy: idle at %0d, required %0d", nm, k, e + 12);
    else pass_cnt++;
    for (int j = e + 1; j <= e + 12 && j < log_q.size(); j++) if (log_q[j].en !== 1'b0) en_cnt++;
    total++;
    if (en_cnt != 0) $display("FAIL %s ifg_tx_en: %0d high cycles in gap, required 0", nm, en_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({t0_data, t0_en, t0_er, t0_done, t0_err, t0_busy, t0_ready} !== 14'h0)
      $display("FAIL reset_dut: outputs %h, required 0", {t0_data, t0_en, t0_er, t0_done, t0_err, t0_busy, t0_ready});
    else pass_cnt++;
    total++;
    if ({t9_data, t9_en, t9_er, t9_done, t9_err, t9_busy, t9_ready} !== 14'h0)
      $display("FAIL reset_dut9: outputs %h, required 0", {t9_data, t9_en, t9_er, t9_done, t9_err, t9_busy, t9_ready});
    else pass_cnt++;
    s_valid = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_crc_check();
    int s, e;
    logic [31:0] f;
    sel = 1'b1;
    for (int i = 0; i < 9; i++) pl[0][i] = 8'h31 + 8'(i);
    clear_log();
    drive(0, 9, 1'b1, -1);
    wait_idle("crc");
    s = find_en(0);
    check_frame("crc", 0, 9, 9, s, e, f);
    total++;
    if (f !== 32'hCBF4_3926) $display("FAIL crc_vector: fcs %h, required cbf43926", f);
    else pass_cnt++;
    check_ifg("crc", e);
    sel = 1'b0;
  endtask

  task automatic test_padding();
    int s, e;
    logic [31:0] f;
    for (int i = 0; i < 14; i++) pl[0][i] = 8'(8'h10 + i * 17);
    clear_log();
    drive(0, 14, 1'b1, -1);
    wait_idle("pad");
    s = find_en(0);
    check_frame("pad", 0, 14, 60, s, e, f);
    check_ifg("pad", e);
  endtask

  task automatic test_back_to_back();
    int sa, ea, sb, eb, rdy_hi;
    logic [31:0] f;
    for (int i = 0; i < 20; i++) pl[0][i] = 8'(8'hE0 ^ i);
    for (int i = 0; i < 64; i++) pl[1][i] = 8'(i * 3 + 5);
    clear_log();
    drive(0, 20, 1'b1, -1);
    drive(1, 64, 1'b1, -1);
    wait_idle("b2b");
    sa = find_en(0);
    check_frame("b2b_a", 0, 20, 60, sa, ea, f);
    sb = find_en(ea + 1);
    total++;
    if (sb != ea + 13) $display("FAIL b2b_gap: second preamble at %0d, required %0d", sb, ea + 13);
    else pass_cnt++;
    rdy_hi = 0;
    for (int k = ea - 3; k <= ea + 19 && k < log_q.size(); k++) if (log_q[k].rdy !== 1'b0) rdy_hi++;
    total++;
    if (rdy_hi != 0) $display("FAIL b2b_ready: s_ready high %0d cycles before DATA, required 0", rdy_hi);
    else pass_cnt++;
    check_frame("b2b_b", 1, 64, 60, sb, eb, f);
  endtask

  task automatic test_underrun();
    int s, e, bad, dn, ec, erc;
    logic [31:0] f;
    for (int i = 0; i < 30; i++) pl[0][i] = 8'(i * 3 + 1);
    clear_log();
    drive(0, 30, 1'b1, 20);
    wait_idle("under");
    s = find_en(0);
    e = (s < 0) ? 0 : run_end(s);
    total++;
    if (s < 0 || e - s + 1 != 29) $display("FAIL under_len: start %0d len %0d, required len 29", s, e - s + 1);
    else pass_cnt++;
    if (s < 0) s = 0;
    total++;
    if ({log_q[e].d, log_q[e].en, log_q[e].er, log_q[e].err} !== {8'h00, 3'b111})
      $display("FAIL under_abort: data/en/er/err %h, required 007", {log_q[e].d, log_q[e].en, log_q[e].er, log_q[e].err});
    else pass_cnt++;
    total++;
    if ({log_q[e+1].en, log_q[e+1].er} !== 2'b00)
      $display("FAIL under_after: en/er %b, required 00", {log_q[e+1].en, log_q[e+1].er});
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 20; i++) if (log_q[s+8+i].d !== pl[0][i]) bad++;
    total++;
    if (bad != 0) $display("FAIL under_body: %0d bad bytes, required 0", bad);
    else pass_cnt++;
    dn = 0; ec = 0; erc = 0;
    foreach (log_q[k]) begin
      if (log_q[k].done === 1'b1) dn++;
      if (log_q[k].err === 1'b1) ec++;
      if (log_q[k].er === 1'b1) erc++;
    end
    total++;
    if (dn != 0 || ec != 1 || erc != 1)
      $display("FAIL under_flags: done %0d err %0d tx_er %0d, required 0 1 1", dn, ec, erc);
    else pass_cnt++;

    for (int i = 0; i < 60; i++) pl[1][i] = 8'(8'hFF - i);
    clear_log();
    drive(1, 60, 1'b1, -1);
    wait_idle("under_next");
    s = find_en(0);
    check_frame("under_next", 1, 60, 60, s, e, f);
  endtask

  task automatic test_oversize();
    int s, e, bad, dn;
    logic [31:0] f;
    for (int i = 0; i < 1516; i++) pl[0][i] = 8'(i * 7 + 3);
    clear_log();
    drive(0, 1516, 1'b1, -1);
    wait_idle("over");
    s = find_en(0);
    e = (s < 0) ? 0 : run_end(s);
    total++;
    if (s < 0 || e - s + 1 != 1523) $display("FAIL over_len: start %0d len %0d, required len 1523", s, e - s + 1);
    else pass_cnt++;
    if (s < 0) s = 0;
    total++;
    if ({log_q[e].d, log_q[e].en, log_q[e].er, log_q[e].err} !== {8'h00, 3'b111})
      $display("FAIL over_abort: data/en/er/err %h, required 007", {log_q[e].d, log_q[e].en, log_q[e].er, log_q[e].err});
    else pass_cnt++;
    bad = 0; dn = 0;
    for (int i = 0; i < 1514; i++) if (log_q[s+8+i].d !== pl[0][i]) bad++;
    foreach (log_q[k]) if (log_q[k].done === 1'b1) dn++;
    total++;
    if (bad != 0 || dn != 0) $display("FAIL over_body: %0d bad bytes, %0d done pulses, required 0 0", bad, dn);
    else pass_cnt++;

    for (int i = 0; i < 1514; i++) pl[1][i] = 8'(i * 5 + 1);
    clear_log();
    drive(1, 1514, 1'b1, -1);
    wait_idle("max");
    s = find_en(0);
    check_frame("max", 1, 1514, 60, s, e, f);
    check_ifg("max", e);
  endtask

  task automatic test_reset_mid_frame();
    int s, e, g;
    logic [31:0] f;
    clear_log();
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b0;
    g = 0;
    while (m_ready !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    total++;
    if (m_tx_en !== 1'b1) $display("FAIL mid_in_frame: tx_en %b, required 1", m_tx_en);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_ready !== 1'b0) $display("FAIL mid_ready_gate: s_ready %b, required 0", m_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({m_tx_data, m_tx_en, m_tx_er, m_done, m_err, m_busy} !== 13'h0)
      $display("FAIL mid_reset: outputs %h, required 0", {m_tx_data, m_tx_en, m_tx_er, m_done, m_err, m_busy});
    else pass_cnt++;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({m_tx_en, m_busy} !== 2'b00) $display("FAIL mid_no_resume: en/busy %b, required 00", {m_tx_en, m_busy});
    else pass_cnt++;

    for (int i = 0; i < 60; i++) pl[0][i] = 8'(i ^ 8'h5A);
    clear_log();
    drive(0, 60, 1'b1, -1);
    wait_idle("mid_after");
    s = find_en(0);
    check_frame("mid_after", 0, 60, 60, s, e, f);
    check_ifg("mid_after", e);
  endtask

  initial begin
    test_reset();
    test_crc_check();
    test_padding();
    test_back_to_back();
    test_underrun();
    test_oversize();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
